// File: rtl/mem_stream_reader.sv
// Streams a block of words out of a synchronous-read memory onto a valid/ready port.
// A 2-entry in-order buffer with a bypass for the word arriving this cycle keeps one word per cycle.
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_en,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   reads_left_q, reads_left_d;
  logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
  logic                  inflight_q;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop_s;
  logic                  rd_en_s;
  logic [2:0]            level_s;

  // The word returning from memory this cycle is visible immediately when the buffer is empty.
  assign out_valid  = (count_q != 2'd0) | inflight_q;
  assign pop_s      = out_valid & out_ready;
  assign level_s    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_en_s    = (state_q == RUN) && (reads_left_q != CNT_ZERO) && (level_s < 3'd2);
  assign mem_r_en   = rd_en_s;
  assign mem_r_addr = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Head of the stream: oldest buffered word, else the bypassed memory word, else zero.
  always_comb begin
    out_data = {DATA_WIDTH{1'b0}};
    if (count_q != 2'd0) begin
      out_data = buf0_q;
    end else if (inflight_q) begin
      out_data = mem_dout;
    end else begin
      out_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Buffer next state: buf0 is always the oldest entry, buf1 the younger one.
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = level_s[1:0];
    case (count_q)
      2'd0: begin
        if (inflight_q && !pop_s) begin
          buf0_d = mem_dout;
        end else begin
          buf0_d = buf0_q;
        end
      end
      2'd1: begin
        if (pop_s && inflight_q) begin
          buf0_d = mem_dout;
        end else if (!pop_s && inflight_q) begin
          buf1_d = mem_dout;
        end else begin
          buf0_d = buf0_q;
        end
      end
      2'd2: begin
        if (pop_s) begin
          buf0_d = buf1_q;
        end else begin
          buf0_d = buf0_q;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Control next state: read issue, word accounting and the IDLE/RUN/FINISH sequence.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reads_left_d = reads_left_q;
    words_left_d = words_left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          addr_d       = base_addr;
          reads_left_d = length;
          words_left_d = length;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rd_en_s) begin
          addr_d       = addr_q + ADDR_ONE;
          reads_left_d = reads_left_q - CNT_ONE;
        end else begin
          addr_d = addr_q;
        end
        if (pop_s) begin
          words_left_d = words_left_q - CNT_ONE;
        end else begin
          words_left_d = words_left_q;
        end
        // A zero-length transfer passes through RUN for one cycle without reading.
        if ((words_left_q == CNT_ZERO) || ((words_left_q == CNT_ONE) && pop_s)) begin
          state_d = FINISH;
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; busy and done are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      reads_left_q <= CNT_ZERO;
      words_left_q <= CNT_ZERO;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      buf0_q       <= {DATA_WIDTH{1'b0}};
      buf1_q       <= {DATA_WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      reads_left_q <= reads_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= rd_en_s;
      count_q      <= count_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FINISH);
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a memory model plus a transfer-level reference that predicts
// read addresses and the word stream from (base, length) and checks every cycle.
module tb_mem_stream_reader;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int MEMSZ = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] mem_r_addr;
  logic          mem_r_en;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [MEMSZ];

  int n_err = 0;
  int n_chk = 0;

  // Reference state for the transfer currently expected.
  bit            active = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] exp_base = '0;
  int            exp_len = 0;
  int            rd_cnt = 0;
  int            pop_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_r_en) mem_dout <= mem[mem_r_addr];
  end

  mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_r_addr(mem_r_addr),
    .mem_r_en  (mem_r_en),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle reference check, sampled mid-cycle.
  task automatic observe();
    logic [AW-1:0] a;
    if (rst) begin
      active     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (active) begin
        if (stall_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (mem_r_en) begin
          a = exp_base + rd_cnt[AW-1:0];
          chk("read_extra", 32'(rd_cnt < exp_len), 32'd1);
          chk("read_addr", 32'(mem_r_addr), 32'(a));
          rd_cnt++;
        end
        if (out_valid) chk("valid_extra", 32'(pop_cnt < exp_len), 32'd1);
        if (out_valid && out_ready) begin
          a = exp_base + pop_cnt[AW-1:0];
          chk("data", 32'(out_data), 32'(mem[a]));
          pop_cnt++;
        end
        if (mem_r_en) chk("outstanding", 32'((rd_cnt - pop_cnt) <= 2), 32'd1);
        if (done) begin
          chk("reads_total", 32'(rd_cnt), 32'(exp_len));
          chk("words_total", 32'(pop_cnt), 32'(exp_len));
          active = 1'b0;
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        chk("idle_quiet", 32'({out_valid, mem_r_en, done}), 32'd0);
        stall_prev = 1'b0;
      end
      // A start is accepted only while the block is idle.
      if (start && !busy) begin
        active     = 1'b1;
        exp_base   = base_addr;
        exp_len    = int'(length);
        rd_cnt     = 0;
        pop_cnt    = 0;
        stall_prev = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic st, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    start     = st;
    out_ready = rdy;
    rst       = rs;
    @(negedge clk);
    observe();
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  // One transfer; exp_done is the expected done cycle after the start cycle (0 = unchecked).
  task automatic run_xfer(input logic [AW-1:0] b, input int l, input bit rnd,
                          input bit inject, input int exp_done);
    int  got;
    int  lim;
    bit  st;
    base_addr = b;
    length    = 12'(l);
    tick(1'b1, 1'b1, 1'b0);
    got = 0;
    lim = 10 * l + 50;
    for (int k = 1; k <= lim && got == 0; k++) begin
      st = inject && (k == 3);
      if (st) begin
        base_addr = b ^ 11'h155;
        length    = 12'd3;
      end
      tick(st, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      chk("busy_run", 32'(busy), 32'd1);
      if (k == 1) chk("lat_valid_t1", 32'(out_valid), 32'd0);
      if (k == 2 && l != 0) chk("lat_valid_t2", 32'(out_valid), 32'd1);
      if (done) got = k;
    end
    chk("done_seen", 32'(got != 0), 32'd1);
    if (exp_done > 0) chk("done_time", 32'(got), 32'(exp_done));
    tick(1'b0, 1'b1, 1'b0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i);

    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_reset_outputs();

    // Directed: identity memory, latency and wrap-around.
    run_xfer(11'h010, 4, 1'b0, 1'b0, 6);
    run_xfer(11'h7FE, 4, 1'b0, 1'b0, 6);
    run_xfer(11'h123, 0, 1'b0, 1'b0, 2);
    run_xfer(11'h040, 6, 1'b0, 1'b1, 8);

    // Random memory contents with a randomly stalling consumer.
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 6; t++) run_xfer(11'($urandom), 8, 1'b1, 1'b0, 0);
    for (int t = 0; t < 6; t++) run_xfer(11'($urandom), $urandom_range(3, 20), 1'b1, t[0], 0);

    // Reset after 3 of 10 words, with a start in the same cycle as reset.
    base_addr = 11'h100;
    length    = 12'd10;
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) tick(1'b0, 1'b1, 1'b0);
    chk("words_before_rst", 32'(pop_cnt), 32'd3);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_reset_outputs();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0);
    run_xfer(11'($urandom), 2, 1'b0, 1'b0, 4);

    // Full-memory transfer.
    run_xfer(11'h5A3, MEMSZ, 1'b0, 1'b0, MEMSZ + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
